rv_fanout_fifo: RTL
===================

# rv_fanout_fifo

Registered ready/valid track buffer that drives one interconnect source onto a configurable set of up to NUM_CONS consumer ports. It sits directly upstream of the fanout ready-reduction stage and holds each word in a 2-entry FIFO. It serves the word to every consumer selected by its mask as an eager fork: each consumer may accept at its own cycle, and the head retires only when all selected consumers have taken it. A bypass mode gives the legacy combinational behaviour: ready is the AND over selected consumers, with no storage.

## Interface
Parameters:
- WIDTH, 17, data width (16-bit value plus stream control bit)
- NUM_CONS, 21, number of consumer ports
- DEPTH, 2, FIFO entries (only 2 supported; pointers are 1 bit)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  stall when low; no state change except flush
- flush  in  1  synchronous clear of FIFO and fork state
- cfg_fifo_en  in  1  1 = registered FIFO mode, 0 = combinational bypass
- cfg_cons_mask  in  NUM_CONS  bit i set = consumer i is in the fanout
- in_data  in  WIDTH  producer data
- in_valid  in  1  producer valid
- in_ready  out  1  buffer can accept
- out_data  out  WIDTH  head word, shared by all consumers
- out_valid  out  NUM_CONS  per-consumer valid
- out_ready  in  NUM_CONS  per-consumer ready

## Operation
- State:
  - mem[0:1] (WIDTH each), wr_ptr, rd_ptr (1 bit each), count (0..2), done[NUM_CONS]
  - done[i] = consumer i already took the current head.
- Registered mode (cfg_fifo_en=1):
  - in_ready = clk_en & (count != 2).
  - push = in_valid & in_ready: write mem[wr_ptr], toggle wr_ptr.
  - out_data = mem[rd_ptr].
  - out_valid[i] = clk_en & (count != 0) & cfg_cons_mask[i] & ~done[i].
  - accept[i] = out_valid[i] & out_ready[i].
  - all_taken = AND over i of (done[i] | accept[i] | ~cfg_cons_mask[i]).
  - pop = clk_en & (count != 0) & all_taken. On pop: toggle rd_ptr and clear done. Otherwise done |= accept.
  - count_next = count + push - pop. Push and pop in the same cycle are legal when count is 1, and when count is 2 and popping (in_ready is still 0 at 2, so no push occurs).
  - A consumer never sees valid twice for the same word, because its done bit masks it off.
  - All-zero mask: each stored word pops in the cycle after it is written; the data is discarded and no out_valid is raised.
- Bypass mode (cfg_fifo_en=0):
  - out_data = in_data.
  - out_valid[i] = in_valid & cfg_cons_mask[i].
  - in_ready = AND over i of (out_ready[i] | ~cfg_cons_mask[i]).
  - count, pointers and done are held at their cleared values; clk_en has no effect.
- Flush:
  - count, pointers and done all clear to 0 in one cycle; mem contents are kept.
  - Flush beats push and pop, and acts even when clk_en=0.
- Configuration changes are legal only while count=0 or together with flush. Changing cfg_cons_mask with a partially taken head is undefined.

## Timing
- Reset (rst_n low, asynchronous): count=0, ptrs=0, done=0, mem=0. Outputs: out_valid=0, out_data=0, in_ready=clk_en in registered mode.
- Registered mode latency: in_valid&in_ready at edge N gives out_valid at N+1 (no flow-through).
- Throughput is 1 word/cycle when all selected consumers are ready. A full buffer with a pop frees a slot visible on in_ready the next cycle.
- Bypass mode latency is 0 cycles; the path is purely combinational.
- Deasserting rst_n mid-transfer drops all buffered words.

## Test plan
- Reset, registered mode, mask=0x3, out_ready=0x3; push 0xA5 then 0x5A back-to-back.
  - Required: out_valid=0x3 with out_data=0xA5 in cycle 1 and 0x5A in cycle 2; in_ready stays 1.
- Skewed fork, mask=0x7, one word 0x111:
  - cycle 1: out_ready=0x1; consumer 0 takes it, out_valid becomes 0x6.
  - cycle 2: out_ready=0x4; out_valid becomes 0x2.
  - cycle 3: out_ready=0x2; pop occurs and count returns to 0.
  - Required: no consumer sees the word twice.
- Full/backpressure: out_ready=0; push 3 words.
  - Required: in_ready drops after 2 pushes and the third word holds.
  - Then raise all ready: words drain in order, in_ready returns to 1 in the cycle after the first pop.
- clk_en=0 with count=1 and all ready.
  - Required: out_valid=0, in_ready=0, no state change. Then flush=1 with clk_en=0 gives count=0.
- Bypass, mask=0x5, in_valid=1.
  - out_ready=0x1: required out_valid=0x5, in_ready=0.
  - out_ready=0x5: required in_ready=1; out_ready bit 1 is ignored.
- Asynchronous rst_n pulse mid-cycle while count=2.
  - Required: out_valid=0 immediately; after release, the first new push appears 1 cycle later.

Source files
------------

// File: rtl/rv_fanout_fifo.sv
// rv_fanout_fifo: 2-entry ready/valid buffer feeding a masked set of
// consumers as an eager fork. Each selected consumer takes the head word
// independently; the head retires once every selected consumer has it.
// With cfg_fifo_en low the block is a purely combinational pass-through.
module rv_fanout_fifo #(
  parameter int unsigned WIDTH    = 17,
  parameter int unsigned NUM_CONS = 21,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                flush,
  input  logic                cfg_fifo_en,
  input  logic [NUM_CONS-1:0] cfg_cons_mask,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [NUM_CONS-1:0] out_valid,
  input  logic [NUM_CONS-1:0] out_ready
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic [NUM_CONS-1:0] done;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                all_taken;
  logic [NUM_CONS-1:0] accept;

  // Output muxing between buffered and bypass paths, plus fork handshake terms
  always_comb begin
    full  = (count == 2'(DEPTH));
    empty = (count == '0);
    if (cfg_fifo_en) begin
      in_ready  = clk_en & ~full;
      out_data  = mem[rd_ptr];
      out_valid = {NUM_CONS{clk_en & ~empty}} & cfg_cons_mask & ~done;
    end else begin
      in_ready  = &(out_ready | ~cfg_cons_mask);
      out_data  = in_data;
      out_valid = {NUM_CONS{in_valid}} & cfg_cons_mask;
    end
    accept    = out_valid & out_ready;
    // A consumer is satisfied if it already took the head, takes it now,
    // or is not part of the fanout at all.
    all_taken = &(done | accept | ~cfg_cons_mask);
    push      = cfg_fifo_en & in_valid & in_ready;
    pop       = cfg_fifo_en & clk_en & ~empty & all_taken;
  end

  // Pointer, occupancy and per-consumer done tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      done   <= '0;
    end else if (flush || !cfg_fifo_en) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      done   <= '0;
    end else if (clk_en) begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        done   <= '0;
      end else begin
        done <= done | accept;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Storage write; contents survive flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule
